// File: rtl/non_max_suppression_stream.sv
// Streaming non-maximum suppression for the Canny pipeline.
// Accepts one {magnitude, direction} pixel per cycle in raster order, keeps two
// previous lines in line buffers plus a 3x3 window, and emits one thinned
// magnitude per input pixel in the same raster order. Image borders are zero.
module non_max_suppression_stream #(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int MAG_W  = 8,
    parameter int STRICT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [MAG_W-1:0] s_mag,
    input  logic [1:0]       s_dir,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [MAG_W-1:0] m_mag,
    output logic             m_last,
    output logic             busy
);

    localparam int CW   = $clog2(IMG_W);
    localparam int RW   = $clog2(IMG_H);
    localparam int NPIX = IMG_W * IMG_H;
    localparam int IW   = $clog2(NPIX + 1);
    localparam int PW   = MAG_W + 2;

    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(NPIX - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t state, state_nx;

    logic          ready_en;
    logic [CW-1:0] in_col;
    logic [RW-1:0] in_row;
    logic [CW-1:0] out_col;
    logic [RW-1:0] out_row;
    logic [IW-1:0] out_idx;

    // Line buffers: lb0 holds the previous line, lb1 the line before that.
    logic [PW-1:0] lb0 [IMG_W];
    logic [PW-1:0] lb1 [IMG_W];

    // win[row][col]: row 0 = oldest line, col 2 = most recent column.
    logic [PW-1:0] win [3][3];
    logic [PW-1:0] col_new [3];

    logic             in_xfer, out_xfer, out_free, load, frame_done;
    logic             in_last_col, in_last_px;
    logic [MAG_W-1:0] ctr, nb_a, nb_b, pix_out;
    logic [1:0]       ctr_dir;
    logic             keep, border;

    assign in_xfer     = s_valid && s_ready;
    assign out_xfer    = m_valid && m_ready;
    assign out_free    = !m_valid || m_ready;
    assign frame_done  = out_xfer && m_last;
    assign in_last_col = (in_col == COL_MAX);
    assign in_last_px  = in_last_col && (in_row == ROW_MAX);
    // Output register loads once per RUN input, or once per free slot in FLUSH
    // until the m_last pixel has been loaded.
    assign load = ((state == RUN) && in_xfer) ||
                  ((state == FLUSH) && !m_last && out_free);

    // State register.
    // NOTE: every clocked process uses non-blocking assignments so all
    // registers update from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic.
    // NOTE: the default assignment at the top keeps this block latch-free.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (in_xfer) state_nx = FILL;
            FILL:  if (in_xfer && in_row == RW'(1) && in_col == '0) state_nx = RUN;
            RUN:   if (in_xfer && in_last_px) state_nx = FLUSH;
            FLUSH: if (frame_done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State-derived outputs.
    always_comb begin
        busy    = (state != IDLE);
        s_ready = ready_en && (state != FLUSH) && out_free;
    end

    // Holds s_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_en <= 1'b0;
        else        ready_en <= 1'b1;
    end

    // Input raster position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_col <= '0;
            in_row <= '0;
        end else if (frame_done) begin
            in_col <= '0;
            in_row <= '0;
        end else if (in_xfer) begin
            if (in_last_col) begin
                in_col <= '0;
                in_row <= in_last_px ? '0 : in_row + RW'(1);
            end else begin
                in_col <= in_col + CW'(1);
            end
        end
    end

    // Line buffers shift one line down at the current column.
    // NOTE: buffer storage has no reset; every entry is rewritten before any
    // interior pixel of a frame reads it.
    always_ff @(posedge clk) begin
        if (in_xfer) begin
            lb1[in_col] <= lb0[in_col];
            lb0[in_col] <= {s_dir, s_mag};
        end
    end

    // Column arriving into the window with this input pixel.
    always_comb begin
        col_new[0] = lb1[in_col];
        col_new[1] = lb0[in_col];
        col_new[2] = {s_dir, s_mag};
    end

    // 3x3 window shifts left by one column per accepted pixel.
    always_ff @(posedge clk) begin
        if (in_xfer) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
                win[r][2] <= col_new[r];
            end
        end
    end

    // Neighbour selection and keep decision on the post-shift window, whose
    // centre is the pixel one line and one column behind the incoming one.
    always_comb begin
        ctr     = win[1][2][MAG_W-1:0];
        ctr_dir = win[1][2][PW-1:MAG_W];
        nb_a    = '0;
        nb_b    = '0;
        case (ctr_dir)
            2'd0: begin
                nb_a = win[1][1][MAG_W-1:0];
                nb_b = col_new[1][MAG_W-1:0];
            end
            2'd1: begin
                nb_a = win[2][1][MAG_W-1:0];
                nb_b = col_new[0][MAG_W-1:0];
            end
            2'd2: begin
                nb_a = win[0][2][MAG_W-1:0];
                nb_b = win[2][2][MAG_W-1:0];
            end
            default: begin
                nb_a = win[0][1][MAG_W-1:0];
                nb_b = col_new[2][MAG_W-1:0];
            end
        endcase
        if (STRICT != 0) keep = (ctr > nb_a) && (ctr > nb_b);
        else             keep = (ctr >= nb_a) && (ctr >= nb_b);
        // Every FLUSH pixel lies on the last row or last column, so the
        // border term alone zeroes them without needing a valid window.
        border  = (out_row == '0) || (out_row == ROW_MAX) ||
                  (out_col == '0) || (out_col == COL_MAX);
        pix_out = (border || !keep) ? '0 : ctr;
    end

    // Output raster position and index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_col <= '0;
            out_row <= '0;
            out_idx <= '0;
        end else if (frame_done) begin
            out_col <= '0;
            out_row <= '0;
            out_idx <= '0;
        end else if (load) begin
            out_idx <= out_idx + IW'(1);
            if (out_col == COL_MAX) begin
                out_col <= '0;
                out_row <= out_row + RW'(1);
            end else begin
                out_col <= out_col + CW'(1);
            end
        end
    end

    // Output register: holds its pixel until downstream takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_mag   <= '0;
            m_last  <= 1'b0;
        end else if (load) begin
            m_valid <= 1'b1;
            m_mag   <= pix_out;
            m_last  <= (out_idx == IDX_MAX);
        end else if (out_xfer) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_non_max_suppression_stream.sv
// Self-checking bench for non_max_suppression_stream on a 5x5 image.
// Two instances share stimulus: dut0 uses the >= tie rule, dut1 the > rule.
module tb_non_max_suppression_stream;

    localparam int W = 5;
    localparam int H = 5;
    localparam int N = W * H;

    logic       clk, rst_n;
    logic       s_valid, m_ready;
    logic [7:0] s_mag;
    logic [1:0] s_dir;
    logic       s_ready0, m_valid0, m_last0, busy0;
    logic [7:0] m_mag0;
    logic       s_ready1, m_valid1, m_last1, busy1;
    logic [7:0] m_mag1;

    non_max_suppression_stream #(.IMG_W(W), .IMG_H(H), .MAG_W(8), .STRICT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready0),
        .s_mag(s_mag), .s_dir(s_dir), .m_valid(m_valid0), .m_ready(m_ready),
        .m_mag(m_mag0), .m_last(m_last0), .busy(busy0));

    non_max_suppression_stream #(.IMG_W(W), .IMG_H(H), .MAG_W(8), .STRICT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready1),
        .s_mag(s_mag), .s_dir(s_dir), .m_valid(m_valid1), .m_ready(m_ready),
        .m_mag(m_mag1), .m_last(m_last1), .busy(busy1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    logic [7:0] stim_mag [2*N];
    logic [1:0] stim_dir [2*N];
    logic [7:0] cur_exp  [N];
    logic [7:0] exp_a    [N];
    logic [7:0] exp_b    [N];
    logic [7:0] exp_c    [N];
    logic [7:0] got0_mag [$];
    logic [7:0] got1_mag [$];
    bit         got0_last[$];
    bit         got1_last[$];
    int         last_pulses = 0;
    int         gap_low = 0;

    bit         stall_prev = 0;
    logic [7:0] st_mag;
    logic       st_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Output monitor, sampled on the falling edge; also checks stall stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", 32'(m_valid0), 32'd1);
                check("stall_mag", 32'(m_mag0), 32'(st_mag));
                check("stall_last", 32'(m_last0), 32'(st_last));
            end
            if (m_valid0 && !m_ready) begin
                check("stall_s_ready", 32'(s_ready0), 32'd0);
                stall_prev = 1;
                st_mag     = m_mag0;
                st_last    = m_last0;
            end else begin
                stall_prev = 0;
            end
            if (m_valid0 && m_ready) begin
                got0_mag.push_back(m_mag0);
                got0_last.push_back(m_last0);
                if (m_last0) last_pulses++;
            end
            if (m_valid1 && m_ready) begin
                got1_mag.push_back(m_mag1);
                got1_last.push_back(m_last1);
            end
        end
    end

    // Reference: border pixels are 0; interior keeps the centre when it beats
    // both neighbours along its direction under the selected tie rule.
    function automatic logic [7:0] ref_pix(input int r, input int c, input bit strict);
        int dr, dc;
        logic [7:0] ctr, a, b;
        if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 8'd0;
        case (stim_dir[r*W + c])
            2'd0:    begin dr =  0; dc = 1; end
            2'd1:    begin dr = -1; dc = 1; end
            2'd2:    begin dr =  1; dc = 0; end
            default: begin dr =  1; dc = 1; end
        endcase
        ctr = stim_mag[r*W + c];
        a   = stim_mag[(r - dr)*W + (c - dc)];
        b   = stim_mag[(r + dr)*W + (c + dc)];
        if (strict) return (ctr > a && ctr > b) ? ctr : 8'd0;
        return (ctr >= a && ctr >= b) ? ctr : 8'd0;
    endfunction

    task automatic load_test(input int slot, input logic [1:0] d);
        logic [7:0] row [W];
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r == 1 || r == 3) row = '{8'd0, 8'd100, 8'd100, 8'd100, 8'd0};
                else if (r == 2)      row = '{8'd0, 8'd100, 8'd255, 8'd100, 8'd0};
                else                  row = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
                stim_mag[slot*N + r*W + c] = row[c];
                stim_dir[slot*N + r*W + c] = d;
            end
        end
    endtask

    task automatic clear_q();
        got0_mag.delete();
        got0_last.delete();
        got1_mag.delete();
        got1_last.delete();
    endtask

    // Streams npix pixels; stop_after > 0 stops driving once that many were accepted.
    task automatic stream(input int npix, input int gap_pct, input bit bp, input int stop_after);
        int sent = 0;
        int cyc  = 0;
        bit xfer;
        while (cyc < 3000) begin
            if (stop_after > 0 && sent >= stop_after) break;
            if (stop_after == 0 && sent >= npix && got0_mag.size() >= npix) break;
            m_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (sent < npix && $urandom_range(0, 99) >= gap_pct) begin
                s_valid = 1'b1;
                s_mag   = stim_mag[sent];
                s_dir   = stim_dir[sent];
            end else begin
                s_valid = 1'b0;
                s_mag   = 8'($urandom);
                s_dir   = 2'($urandom);
            end
            @(negedge clk);
            xfer = s_valid && s_ready0;
            if (sent == N && sent < npix && !s_ready0) gap_low++;
            @(posedge clk);
            #1;
            if (xfer) sent++;
            cyc++;
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        if (stop_after == 0) check("stream_done", 32'(cyc < 3000), 32'd1);
    endtask

    task automatic cmp_frame(input string tag, input bit which, input int base);
        int sz = which ? got1_mag.size() : got0_mag.size();
        check({tag, "_count"}, 32'(sz >= base + N), 32'd1);
        for (int k = 0; k < N; k++) begin
            if (base + k < sz) begin
                check({tag, "_mag"}, 32'(which ? got1_mag[base+k] : got0_mag[base+k]),
                      32'(cur_exp[k]));
                check({tag, "_last"}, 32'(which ? got1_last[base+k] : got0_last[base+k]),
                      32'(k == N - 1));
            end
        end
    endtask

    initial begin
        exp_a = '{0,0,0,0,0,  0,100,100,100,0,  0,0,255,0,0,    0,100,100,100,0,  0,0,0,0,0};
        exp_b = '{0,0,0,0,0,  0,0,0,0,0,        0,0,255,0,0,    0,0,0,0,0,        0,0,0,0,0};
        exp_c = '{0,0,0,0,0,  0,100,0,100,0,    0,100,255,100,0, 0,100,0,100,0,   0,0,0,0,0};

        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_mag   = '0;
        s_dir   = '0;
        m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", 32'(s_ready0), 32'd0);
        check("rst_m_valid", 32'(m_valid0), 32'd0);
        check("rst_m_mag", 32'(m_mag0), 32'd0);
        check("rst_m_last", 32'(m_last0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_busy1", 32'(busy1), 32'd0);
        check("rst_s_ready1", 32'(s_ready1), 32'd0);

        rst_n = 1'b1;
        @(negedge clk);
        check("ready_before_edge", 32'(s_ready0), 32'd0);
        @(negedge clk);
        check("ready_after_edge", 32'(s_ready0), 32'd1);
        @(posedge clk);
        #1;

        // Directed image, dir 0: dut0 (>=) and dut1 (>) run side by side.
        load_test(0, 2'd0);
        clear_q();
        stream(N, 0, 0, 0);
        cur_exp = exp_a;
        cmp_frame("dir0_ge", 1'b0, 0);
        cur_exp = exp_b;
        cmp_frame("dir0_gt", 1'b1, 0);

        // Same image, dir 2.
        load_test(0, 2'd2);
        clear_q();
        stream(N, 0, 0, 0);
        cur_exp = exp_c;
        cmp_frame("dir2_ge", 1'b0, 0);

        // Backpressure and input gaps on the dir 0 image.
        load_test(0, 2'd0);
        clear_q();
        stream(N, 40, 1, 0);
        cur_exp = exp_a;
        cmp_frame("bp", 1'b0, 0);
        check("bp_exact_count", 32'(got0_mag.size()), 32'(N));

        // Abort after 12 accepted pixels, then a clean frame.
        stream(N, 30, 1, 12);
        rst_n = 1'b0;
        #1;
        check("abort_m_valid", 32'(m_valid0), 32'd0);
        check("abort_busy", 32'(busy0), 32'd0);
        check("abort_s_ready", 32'(s_ready0), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_q();
        stream(N, 0, 0, 0);
        cur_exp = exp_a;
        cmp_frame("after_abort", 1'b0, 0);

        // Random images against the reference model, both tie rules.
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < N; i++) begin
                stim_mag[i] = 8'($urandom_range(0, 7) * 36);
                stim_dir[i] = 2'($urandom);
            end
            clear_q();
            stream(N, 25, 1, 0);
            for (int k = 0; k < N; k++) cur_exp[k] = ref_pix(k / W, k % W, 1'b0);
            cmp_frame("rand_ge", 1'b0, 0);
            for (int k = 0; k < N; k++) cur_exp[k] = ref_pix(k / W, k % W, 1'b1);
            cmp_frame("rand_gt", 1'b1, 0);
        end

        // Back-to-back frames with s_valid held high. Between frames s_ready is
        // low for the IMG_W+1 flush loads plus the cycle that hands over m_last.
        load_test(0, 2'd0);
        load_test(1, 2'd2);
        clear_q();
        last_pulses = 0;
        gap_low     = 0;
        stream(2 * N, 0, 0, 0);
        cur_exp = exp_a;
        cmp_frame("b2b_f1", 1'b0, 0);
        cur_exp = exp_c;
        cmp_frame("b2b_f2", 1'b0, N);
        check("b2b_last_pulses", 32'(last_pulses), 32'd2);
        check("b2b_ready_low", 32'(gap_low), 32'(W + 2));
        check("b2b_idle", 32'(busy0), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
